ppg_led_scheduler: RTL and testbench
====================================

PPG_LED_SCHEDULER -- requirements
Module: ppg_led_scheduler

Interface
REQ-001 Parameters SHALL be:
- SETTLE_CYC, default 16: LED-on cycles before each sample, legal 1..255.
- GAP_CYC, default 32: all-LEDs-off cycles between frames, legal 1..255.

REQ-002 Ports SHALL be:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- enable  in  1  run sequencer.
- cfg_load  in  1  one-cycle pulse that latches the cfg_* inputs into shadow registers.
- cfg_dc_red, cfg_dc_ir  in  7  DC-compensation codes.
- cfg_pga_red, cfg_pga_ir  in  4  PGA gain codes.
- adc  in  8  ADC result.
- sample_ready  in  1  consumer accepts sample.
- clr_overrun  in  1  clears overrun.
- led_red, led_ir  out  1  LED drives.
- dc_comp  out  7  applied DC code.
- pga_gain  out  4  applied gain.
- sample  out  8  captured ADC value.
- sample_ch  out  2  channel tag: 0 RED, 1 IR, 2 AMB.
- sample_valid  out  1  sample pending.
- overrun  out  1  sticky sample-loss flag.
- busy  out  1  state is not IDLE.

Function
REQ-003 States SHALL be IDLE, RED_SET, RED_SMP, IR_SET, IR_SMP, AMB_SET, AMB_SMP, GAP.
REQ-004 IDLE SHALL go to RED_SET when enable=1.
REQ-005 Active states SHALL go to IDLE on the next edge when enable=0; LEDs go off and no sample is emitted.
REQ-006 The active-state sequence SHALL be:
- RED_SET → RED_SMP → IR_SET → IR_SMP → AMB_SET → AMB_SMP → GAP → RED_SET.
- Each *_SET lasts SETTLE_CYC cycles.
- Each *_SMP lasts 1 cycle.
- GAP lasts GAP_CYC cycles.
- Without AMBIENT_SAMPLE_EN, IR_SMP → GAP.
REQ-007 Outputs per state SHALL be:
- RED_SET/RED_SMP: led_red=1, dc_comp=dc_red shadow, pga_gain=pga_red shadow.
- IR_SET/IR_SMP: led_ir=1 with the IR shadows.
- All other states: LEDs=0, dc_comp=64, pga_gain=0.
- led_red and led_ir SHALL never be 1 simultaneously.
REQ-008 cfg_load SHALL write the pending registers.
REQ-009 Pending values SHALL be copied to the shadow registers only on entry to RED_SET, so settings never change mid-frame.
REQ-010 A single 8-bit counter SHALL time *_SET and GAP, reloaded on each state entry; it SHALL never wrap.
REQ-011 In each *_SMP cycle, adc SHALL be registered into sample with its sample_ch tag; sample_valid=1 from the following cycle.
REQ-012 sample_valid SHALL stay high until a cycle with sample_valid=1 and sample_ready=1; it clears on the next edge.
- If a new capture coincides with that acceptance, valid stays 1 with the new data.
REQ-013 A capture while sample_valid=1 and sample_ready=0 SHALL overwrite sample and set overrun.
REQ-014 overrun SHALL clear only on clr_overrun=1 or reset.
- If clr_overrun coincides with a new overrun event, set wins.
REQ-015 Each frame SHALL emit samples in RED, IR[, AMB] order.

Reset
REQ-016 On rst_n=0 the block SHALL asynchronously force:
- state=IDLE, counter=0.
- led_red=led_ir=0, dc_comp=64, pga_gain=0.
- sample=0, sample_ch=0, sample_valid=0, overrun=0, busy=0.
- pending and shadow registers: dc=64, pga=0.
REQ-017 Reset asserted mid-frame SHALL discard any pending sample.

Configuration
REQ-018 Macro AMBIENT_SAMPLE_EN SHALL control the ambient phase:
- Defined: AMB_SET/AMB_SMP are included and produce a LED-off sample tagged sample_ch=2.
- Undefined: those states and the tag 2 are never produced, and the frame is 2·(SETTLE_CYC+1)+GAP_CYC cycles long.

Verification
REQ-019 Reset, then enable=1 with SETTLE_CYC=16: led_red rises the cycle after enable; the first sample_valid occurs 18 cycles after enable with sample_ch=0.
REQ-020 Pulse cfg_load with dc_red=0x2A during IR_SET: dc_comp shows the old value for the rest of the frame and 0x2A in the next RED_SET.
REQ-021 Hold sample_ready=0 for a full frame: sample holds the last capture and overrun=1; pulsing clr_overrun clears it.
REQ-022 Drop enable in the middle of IR_SET: IDLE on the next edge, LEDs=0, no IR sample emitted, busy=0.
REQ-023 Build with AMBIENT_SAMPLE_EN and adc=0x80: samples are tagged 0, 1, 2 per frame, and both LEDs=0 during AMB states; the build without the macro emits no tag 2.
REQ-024 Assert rst_n=0 while sample_valid=1: all outputs return to the REQ-016 values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/ppg_led_scheduler.sv
// ppg_led_scheduler: PPG LED/sample sequencer (RED, IR, optional AMB when AMBIENT_SAMPLE_EN is defined, then GAP)
module ppg_led_scheduler #(
    parameter int SETTLE_CYC = 16,
    parameter int GAP_CYC    = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       cfg_load,
    input  logic [6:0] cfg_dc_red,
    input  logic [6:0] cfg_dc_ir,
    input  logic [3:0] cfg_pga_red,
    input  logic [3:0] cfg_pga_ir,
    input  logic [7:0] adc,
    input  logic       sample_ready,
    input  logic       clr_overrun,
    output logic       led_red,
    output logic       led_ir,
    output logic [6:0] dc_comp,
    output logic [3:0] pga_gain,
    output logic [7:0] sample,
    output logic [1:0] sample_ch,
    output logic       sample_valid,
    output logic       overrun,
    output logic       busy
);
    typedef enum logic [2:0] {IDLE, RED_SET, RED_SMP, IR_SET, IR_SMP, AMB_SET, AMB_SMP, GAP} state_t;
    localparam logic [7:0] SET_LD = 8'(SETTLE_CYC - 1);
    localparam logic [7:0] GAP_LD = 8'(GAP_CYC - 1);
    state_t     state, state_nxt;
    logic [7:0] cnt, cnt_nxt;
    logic [6:0] pd_dc_red, pd_dc_ir, sh_dc_red, sh_dc_ir;
    logic [3:0] pd_pga_red, pd_pga_ir, sh_pga_red, sh_pga_ir;
    logic       cap, enter_red;
    logic [1:0] cap_ch;
    // next-state and counter reload; dropping enable returns to IDLE from anywhere
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (!enable) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_nxt = RED_SET;
                    cnt_nxt   = SET_LD;
                end
                RED_SET, IR_SET, AMB_SET: begin
                    if (cnt == '0)
                        state_nxt = (state == RED_SET) ? RED_SMP : (state == IR_SET) ? IR_SMP : AMB_SMP;
                    else
                        cnt_nxt = cnt - 8'd1;
                end
                RED_SMP: begin
                    state_nxt = IR_SET;
                    cnt_nxt   = SET_LD;
                end
`ifdef AMBIENT_SAMPLE_EN
                IR_SMP: begin
                    state_nxt = AMB_SET;
                    cnt_nxt   = SET_LD;
                end
`else
                IR_SMP: begin
                    state_nxt = GAP;
                    cnt_nxt   = GAP_LD;
                end
`endif
                AMB_SMP: begin
                    state_nxt = GAP;
                    cnt_nxt   = GAP_LD;
                end
                GAP: begin
                    if (cnt == '0) begin
                        state_nxt = RED_SET;
                        cnt_nxt   = SET_LD;
                    end else begin
                        cnt_nxt = cnt - 8'd1;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end
    assign enter_red = (state_nxt == RED_SET) && (state != RED_SET);
    assign cap       = enable && (state inside {RED_SMP, IR_SMP, AMB_SMP});
    assign cap_ch    = (state == RED_SMP) ? 2'd0 : (state == IR_SMP) ? 2'd1 : 2'd2;
    // state/counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end
    // pending registers take cfg_load; shadows refresh only at frame start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pd_dc_red  <= 7'd64;
            pd_dc_ir   <= 7'd64;
            pd_pga_red <= '0;
            pd_pga_ir  <= '0;
            sh_dc_red  <= 7'd64;
            sh_dc_ir   <= 7'd64;
            sh_pga_red <= '0;
            sh_pga_ir  <= '0;
        end else begin
            if (cfg_load) begin
                pd_dc_red  <= cfg_dc_red;
                pd_dc_ir   <= cfg_dc_ir;
                pd_pga_red <= cfg_pga_red;
                pd_pga_ir  <= cfg_pga_ir;
            end
            if (enter_red) begin
                sh_dc_red  <= pd_dc_red;
                sh_dc_ir   <= pd_dc_ir;
                sh_pga_red <= pd_pga_red;
                sh_pga_ir  <= pd_pga_ir;
            end
        end
    end
    // sample capture, valid handshake and sticky overrun (set beats clear)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample       <= '0;
            sample_ch    <= '0;
            sample_valid <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            if (cap) begin
                sample    <= adc;
                sample_ch <= cap_ch;
            end
            sample_valid <= cap || (sample_valid && !sample_ready);
            overrun      <= (cap && sample_valid && !sample_ready) || (overrun && !clr_overrun);
        end
    end
    assign led_red  = state inside {RED_SET, RED_SMP};
    assign led_ir   = state inside {IR_SET, IR_SMP};
    assign dc_comp  = led_red ? sh_dc_red : led_ir ? sh_dc_ir : 7'd64;
    assign pga_gain = led_red ? sh_pga_red : led_ir ? sh_pga_ir : 4'd0;
    assign busy     = state != IDLE;
endmodule

// File: tb/tb_ppg_led_scheduler.sv
// tb_ppg_led_scheduler: random stimulus against a frame-position reference model
module tb_ppg_led_scheduler;
    localparam int S = 16;
    localparam int G = 32;
`ifdef AMBIENT_SAMPLE_EN
    localparam int NPH = 3;
`else
    localparam int NPH = 2;
`endif
    localparam int F = NPH * (S + 1) + G;
    logic       clk = 1'b0, rst_n = 1'b0, enable = 1'b0, cfg_load = 1'b0;
    logic       sample_ready = 1'b0, clr_overrun = 1'b0;
    logic [6:0] cfg_dc_red = '0, cfg_dc_ir = '0;
    logic [3:0] cfg_pga_red = '0, cfg_pga_ir = '0;
    logic [7:0] adc = '0;
    logic       led_red, led_ir, sample_valid, overrun, busy;
    logic [6:0] dc_comp;
    logic [3:0] pga_gain;
    logic [7:0] sample;
    logic [1:0] sample_ch;
    int checks = 0, passes = 0, n;
    bit         m_act, m_v, m_ov;
    int         m_t;
    logic [6:0] pd_r, pd_i, sh_r, sh_i;
    logic [3:0] pg_r, pg_i, sg_r, sg_i;
    logic [7:0] m_smp;
    logic [1:0] m_ch;

    ppg_led_scheduler #(.SETTLE_CYC(S), .GAP_CYC(G)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .cfg_load(cfg_load),
        .cfg_dc_red(cfg_dc_red), .cfg_dc_ir(cfg_dc_ir),
        .cfg_pga_red(cfg_pga_red), .cfg_pga_ir(cfg_pga_ir),
        .adc(adc), .sample_ready(sample_ready), .clr_overrun(clr_overrun),
        .led_red(led_red), .led_ir(led_ir), .dc_comp(dc_comp), .pga_gain(pga_gain),
        .sample(sample), .sample_ch(sample_ch), .sample_valid(sample_valid),
        .overrun(overrun), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic m_reset();
        m_act = 0; m_t = 0; m_v = 0; m_ov = 0; m_smp = '0; m_ch = '0;
        pd_r = 7'd64; pd_i = 7'd64; sh_r = 7'd64; sh_i = 7'd64;
        pg_r = '0; pg_i = '0; sg_r = '0; sg_i = '0;
    endtask

    // one clock edge of the reference: frame position m_t counts cycles since RED_SET entry
    task automatic m_step();
        bit cap = 0;
        int ch = 0;
        for (int k = 0; k < NPH; k++)
            if (m_act && enable && m_t == k * (S + 1) + S) begin cap = 1; ch = k; end
        if (cap) begin
            m_ov  = (m_v && !sample_ready) || (m_ov && !clr_overrun);
            m_smp = adc;
            m_ch  = 2'(ch);
            m_v   = 1;
        end else begin
            m_ov = m_ov && !clr_overrun;
            if (m_v && sample_ready) m_v = 0;
        end
        if (enable && (!m_act || m_t == F - 1)) begin
            sh_r = pd_r; sh_i = pd_i; sg_r = pg_r; sg_i = pg_i;
        end
        if (cfg_load) begin
            pd_r = cfg_dc_red; pd_i = cfg_dc_ir; pg_r = cfg_pga_red; pg_i = cfg_pga_ir;
        end
        if (!enable) begin m_act = 0; m_t = 0; end
        else if (!m_act) begin m_act = 1; m_t = 0; end
        else m_t = (m_t + 1) % F;
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    endtask

    task automatic check_all();
        bit er = m_act && m_t <= S;
        bit ei = m_act && m_t > S && m_t <= 2 * S + 1;
        chk("led_red", 32'(led_red), 32'(er));
        chk("led_ir", 32'(led_ir), 32'(ei));
        chk("led_excl", 32'(led_red & led_ir), 32'd0);
        chk("dc_comp", 32'(dc_comp), 32'(er ? sh_r : ei ? sh_i : 7'd64));
        chk("pga_gain", 32'(pga_gain), 32'(er ? sg_r : ei ? sg_i : 4'd0));
        chk("sample", 32'(sample), 32'(m_smp));
        chk("sample_ch", 32'(sample_ch), 32'(m_ch));
        chk("sample_valid", 32'(sample_valid), 32'(m_v));
        chk("overrun", 32'(overrun), 32'(m_ov));
        chk("busy", 32'(busy), 32'(m_act));
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) m_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic rand_in(bit fast_ready);
        enable       = ($urandom % 300) != 0;
        cfg_load     = ($urandom % 8) == 0;
        cfg_dc_red   = 7'($urandom);
        cfg_dc_ir    = 7'($urandom);
        cfg_pga_red  = 4'($urandom);
        cfg_pga_ir   = 4'($urandom);
        adc          = 8'($urandom);
        sample_ready = fast_ready ? 1'($urandom) : (($urandom % 8) == 0);
        clr_overrun  = ($urandom % 16) == 0;
    endtask

    initial begin
        m_reset();
        #12;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        enable = 1'b1;
        sample_ready = 1'b0;
        tick();
        chk("led_red_rise", 32'(led_red), 32'd1);
        n = 1;
        while (!sample_valid && n < 100) begin
            tick();
            n++;
        end
        chk("first_valid_latency", 32'(n), 32'd18);
        chk("first_ch", 32'(sample_ch), 32'd0);
        for (int i = 0; i < 1500; i++) begin
            rand_in(1'b1);
            tick();
        end
        for (int i = 0; i < 1500; i++) begin
            rand_in(1'b0);
            tick();
        end
        enable = 1'b1; cfg_load = 1'b0; clr_overrun = 1'b0; sample_ready = 1'b0;
        n = 0;
        while (!m_v && n < 200) begin
            tick();
            n++;
        end
        chk("valid_before_rst", 32'(sample_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1 m_reset();
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        enable = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
